// File: rtl/csc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csc_pkg
// Brief    : Shared types and constants for the csc_multi colour converter.
// Revision : 1.0
// ============================================================================
package csc_pkg;

    typedef enum logic [1:0] {
        CSC_BYPASS = 2'd0,
        CSC_YCBCR  = 2'd1,
        CSC_GRAY   = 2'd2,
        CSC_RSVD   = 2'd3
    } csc_mode_e;

    localparam int CSC_FRAC_W = 8;
    localparam int CSC_LAT    = 3;

    // BT.601 magnitudes in 8-bit fixed point; signs are applied in the sums
    localparam logic [7:0] C_Y_R  = 8'd77;
    localparam logic [7:0] C_Y_G  = 8'd150;
    localparam logic [7:0] C_Y_B  = 8'd29;
    localparam logic [7:0] C_CB_R = 8'd43;
    localparam logic [7:0] C_CB_G = 8'd85;
    localparam logic [7:0] C_CB_B = 8'd128;
    localparam logic [7:0] C_CR_R = 8'd128;
    localparam logic [7:0] C_CR_G = 8'd107;
    localparam logic [7:0] C_CR_B = 8'd21;

endpackage
`default_nettype wire

// File: rtl/csc_sync_delay.sv
`default_nettype none
// ============================================================================
// Module   : csc_sync_delay
// Brief    : N-stage shift register carrying {hsync, vsync, de} alongside data.
// Revision : 1.0
// ============================================================================
module csc_sync_delay #(
    parameter int N = 3,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_sync,
    output logic [W-1:0] o_sync
);

    logic [W-1:0] r_pipe [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_sync;
            for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_sync = r_pipe[N-1];

endmodule
`default_nettype wire

// File: rtl/csc_multi.sv
`default_nettype none
// ============================================================================
// Module   : csc_multi
// Brief    : 3-stage RGB -> bypass / BT.601 YCbCr / gray converter, mode
//            switched only on a vsync rising edge. Define CSC_ROUND_EN to
//            round half up instead of truncating.
// Revision : 1.0
// ============================================================================
module csc_multi
    import csc_pkg::*;
#(
    parameter int         DATA_W   = 8,
    parameter logic [1:0] MODE_RST = 2'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  RGB_hsync,
    input  logic                  RGB_vsync,
    input  logic [3*DATA_W-1:0]   RGB_data,
    input  logic                  RGB_de,
    output logic                  CSC_hsync,
    output logic                  CSC_vsync,
    output logic [3*DATA_W-1:0]   CSC_data,
    output logic                  CSC_de,
    output logic [1:0]            mode_active
);

    localparam int PW = DATA_W + CSC_FRAC_W;
    localparam int SW = DATA_W + 10;

    localparam logic signed [SW-1:0] C_OFF = {2'b00, 1'b1, {(DATA_W+7){1'b0}}};
    localparam logic signed [SW-1:0] C_MAX = {{10{1'b0}}, {DATA_W{1'b1}}};
`ifdef CSC_ROUND_EN
    localparam logic signed [SW-1:0] C_RND = SW'(128);
`else
    localparam logic signed [SW-1:0] C_RND = '0;
`endif

    logic              r_vs_d;
    logic [1:0]        r_mode_active;
    logic              w_rise;
    logic [1:0]        w_mode_eff;
    logic [DATA_W-1:0] w_r, w_g, w_b;

    logic [DATA_W-1:0] r1_r, r1_g, r1_b;
    csc_mode_e         r1_mode;
    logic [PW-1:0]     r1_p_yr, r1_p_yg, r1_p_yb;
    logic [PW-1:0]     r1_p_cbr, r1_p_cbg, r1_p_cbb;
    logic [PW-1:0]     r1_p_crr, r1_p_crg, r1_p_crb;

    logic [DATA_W-1:0] r2_r, r2_g, r2_b;
    csc_mode_e         r2_mode;
    logic signed [SW-1:0] r2_y, r2_cb, r2_cr;

    logic [DATA_W-1:0]   w_y, w_cb, w_cr;
    logic [3*DATA_W-1:0] w_sel;
    logic [3*DATA_W-1:0] r3_data;

    // The pixel arriving with the vsync edge already sees the new mode
    assign w_rise     = RGB_vsync & ~r_vs_d;
    assign w_mode_eff = w_rise ? mode : r_mode_active;
    assign {w_r, w_g, w_b} = RGB_data;

    function automatic logic [DATA_W-1:0] f_clamp(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] s;
        s = (v + C_RND) >>> CSC_FRAC_W;
        if (s[SW-1])
            f_clamp = '0;
        else if (s > C_MAX)
            f_clamp = '1;
        else
            f_clamp = s[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d        <= 1'b0;
            r_mode_active <= MODE_RST;
        end else begin
            r_vs_d <= RGB_vsync;
            if (w_rise) r_mode_active <= mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_r     <= '0;
            r1_g     <= '0;
            r1_b     <= '0;
            r1_mode  <= CSC_BYPASS;
            r1_p_yr  <= '0;
            r1_p_yg  <= '0;
            r1_p_yb  <= '0;
            r1_p_cbr <= '0;
            r1_p_cbg <= '0;
            r1_p_cbb <= '0;
            r1_p_crr <= '0;
            r1_p_crg <= '0;
            r1_p_crb <= '0;
        end else begin
            r1_r     <= w_r;
            r1_g     <= w_g;
            r1_b     <= w_b;
            r1_mode  <= csc_mode_e'(w_mode_eff);
            r1_p_yr  <= PW'(w_r) * PW'(C_Y_R);
            r1_p_yg  <= PW'(w_g) * PW'(C_Y_G);
            r1_p_yb  <= PW'(w_b) * PW'(C_Y_B);
            r1_p_cbr <= PW'(w_r) * PW'(C_CB_R);
            r1_p_cbg <= PW'(w_g) * PW'(C_CB_G);
            r1_p_cbb <= PW'(w_b) * PW'(C_CB_B);
            r1_p_crr <= PW'(w_r) * PW'(C_CR_R);
            r1_p_crg <= PW'(w_g) * PW'(C_CR_G);
            r1_p_crb <= PW'(w_b) * PW'(C_CR_B);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_r    <= '0;
            r2_g    <= '0;
            r2_b    <= '0;
            r2_mode <= CSC_BYPASS;
            r2_y    <= '0;
            r2_cb   <= '0;
            r2_cr   <= '0;
        end else begin
            r2_r    <= r1_r;
            r2_g    <= r1_g;
            r2_b    <= r1_b;
            r2_mode <= r1_mode;
            r2_y    <= $signed(SW'(r1_p_yr)) + $signed(SW'(r1_p_yg)) + $signed(SW'(r1_p_yb));
            r2_cb   <= C_OFF - $signed(SW'(r1_p_cbr)) - $signed(SW'(r1_p_cbg))
                             + $signed(SW'(r1_p_cbb));
            r2_cr   <= C_OFF + $signed(SW'(r1_p_crr)) - $signed(SW'(r1_p_crg))
                             - $signed(SW'(r1_p_crb));
        end
    end

    assign w_y  = f_clamp(r2_y);
    assign w_cb = f_clamp(r2_cb);
    assign w_cr = f_clamp(r2_cr);

    // Reserved mode falls through to bypass
    always_comb begin
        w_sel = {r2_r, r2_g, r2_b};
        case (r2_mode)
            CSC_YCBCR: w_sel = {w_y, w_cb, w_cr};
            CSC_GRAY:  w_sel = {w_y, w_y, w_y};
            default:   w_sel = {r2_r, r2_g, r2_b};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r3_data <= '0;
        else
            r3_data <= w_sel;
    end

    csc_sync_delay #(
        .N (CSC_LAT),
        .W (3)
    ) u_sync_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sync ({RGB_hsync, RGB_vsync, RGB_de}),
        .o_sync ({CSC_hsync, CSC_vsync, CSC_de})
    );

    assign CSC_data    = CSC_de ? r3_data : '0;
    assign mode_active = r_mode_active;

endmodule
`default_nettype wire

// File: tb/tb_csc_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_csc_multi
// Brief    : Randomised self-checking bench for csc_multi at DATA_W 8 and 10.
// Revision : 1.0
// ============================================================================
module tb_csc_multi;

`ifdef CSC_ROUND_EN
    localparam int         RND     = 128;
    localparam logic [23:0] C_RED8 = 24'h4D55FF;
`else
    localparam int         RND     = 0;
    localparam logic [23:0] C_RED8 = 24'h4C55FF;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        hs, vs, de;
    logic [23:0] d8;
    logic [29:0] d10;

    logic        o8_hs, o8_vs, o8_de, o10_hs, o10_vs, o10_de;
    logic [23:0] o8_data;
    logic [29:0] o10_data;
    logic [1:0]  o8_mode, o10_mode;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic        hs, vs, de;
        logic [23:0] d8;
        logic [29:0] d10;
    } exp_t;

    exp_t q[$];
    int   m_mode;
    bit   m_vs_d;

    always #5 clk = ~clk;

    csc_multi #(.DATA_W(8), .MODE_RST(2'd0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .RGB_hsync(hs), .RGB_vsync(vs), .RGB_data(d8), .RGB_de(de),
        .CSC_hsync(o8_hs), .CSC_vsync(o8_vs), .CSC_data(o8_data), .CSC_de(o8_de),
        .mode_active(o8_mode)
    );

    csc_multi #(.DATA_W(10), .MODE_RST(2'd0)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .RGB_hsync(hs), .RGB_vsync(vs), .RGB_data(d10), .RGB_de(de),
        .CSC_hsync(o10_hs), .CSC_vsync(o10_vs), .CSC_data(o10_data), .CSC_de(o10_de),
        .mode_active(o10_mode)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(int v, int w);
        int s;
        s = v >>> 8;
        if (s < 0) return 0;
        if (s > (1 << w) - 1) return (1 << w) - 1;
        return s;
    endfunction

    // Straight from the conversion equations, real integer arithmetic
    function automatic logic [29:0] model_px(int w, int md, int r, int g, int b);
        int off, y, cb, cr;
        off = 1 << (w - 1 + 8);
        y   = clampv(77*r + 150*g + 29*b + RND, w);
        cb  = clampv(-43*r - 85*g + 128*b + off + RND, w);
        cr  = clampv(128*r - 107*g - 21*b + off + RND, w);
        case (md)
            1:       return 30'((y << (2*w)) | (cb << w) | cr);
            2:       return 30'((y << (2*w)) | (y << w) | y);
            default: return 30'((r << (2*w)) | (g << w) | b);
        endcase
    endfunction

    function automatic int to10(int c);
        return (c << 2) | (c >> 6);
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sync8",  {29'd0, o8_hs, o8_vs, o8_de},  {29'd0, e.hs, e.vs, e.de});
        chk("sync10", {29'd0, o10_hs, o10_vs, o10_de}, {29'd0, e.hs, e.vs, e.de});
        chk("data8",  {8'd0, o8_data}, {8'd0, e.d8});
        chk("data10", {2'd0, o10_data}, {2'd0, e.d10});
        chk("mode8",  {30'd0, o8_mode}, 32'(m_mode));
        chk("mode10", {30'd0, o10_mode}, 32'(m_mode));
    endtask

    task automatic px(input bit h, input bit v, input bit d, input int md,
                      input int r, input int g, input int b);
        exp_t e;
        hs   = h;
        vs   = v;
        de   = d;
        mode = 2'(md);
        d8   = {8'(r), 8'(g), 8'(b)};
        d10  = {10'(to10(r)), 10'(to10(g)), 10'(to10(b))};
        if (v && !m_vs_d) m_mode = md;
        m_vs_d = v;
        e.hs  = h;
        e.vs  = v;
        e.de  = d;
        e.d8  = d ? 24'(model_px(8, m_mode, r, g, b)) : 24'd0;
        e.d10 = d ? model_px(10, m_mode, to10(r), to10(g), to10(b)) : 30'd0;
        q.push_back(e);
        tick();
    endtask

    task automatic model_reset();
        exp_t z;
        z.hs = 0; z.vs = 0; z.de = 0; z.d8 = '0; z.d10 = '0;
        q.delete();
        m_mode = 0;
        m_vs_d = 0;
        q.push_back(z);
        q.push_back(z);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sync"}, {26'd0, o8_hs, o8_vs, o8_de, o10_hs, o10_vs, o10_de}, 32'd0);
        chk({tag, "_d8"},   {8'd0, o8_data}, 32'd0);
        chk({tag, "_d10"},  {2'd0, o10_data}, 32'd0);
        chk({tag, "_mode"}, {28'd0, o8_mode, o10_mode}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 0; hs = 0; vs = 0; de = 0; d8 = '0; d10 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        #4 rst_n = 1'b1;
        model_reset();

        // Bypass: red with hsync, 3 cycles of latency
        px(1, 0, 1, 0, 255, 0, 0);
        px(0, 0, 0, 0, 0, 0, 0);
        px(0, 0, 0, 0, 0, 0, 0);
        chk("byp_red", {8'd0, o8_data}, 32'hFF0000);
        chk("byp_hs",  {31'd0, o8_hs}, 32'd1);

        // YCbCr latched at the edge, same-cycle pixel converted
        px(0, 1, 1, 1, 255, 0, 0);
        chk("ycc_mode", {30'd0, o8_mode}, 32'd1);
        px(0, 1, 1, 0, 255, 255, 255);
        px(0, 0, 1, 0, 0, 0, 0);
        chk("ycc_red", {8'd0, o8_data}, {8'd0, C_RED8});
        px(0, 0, 0, 0, 0, 0, 0);
        chk("ycc_white8",  {8'd0, o8_data}, 32'hFF8080);
        chk("ycc_white10", {2'd0, o10_data}, {2'd0, 10'd1023, 10'd512, 10'd512});
        px(0, 0, 0, 0, 0, 0, 0);
        chk("ycc_black", {8'd0, o8_data}, 32'h008080);

        // Gray
        px(0, 1, 1, 2, 255, 255, 255);
        px(0, 0, 0, 2, 0, 0, 0);
        px(0, 0, 0, 2, 0, 0, 0);
        chk("gray_white", {8'd0, o8_data}, 32'hFFFFFF);

        // Mid-frame change holds until the next vsync edge
        px(0, 1, 1, 0, 10, 20, 30);
        px(0, 1, 1, 1, 40, 50, 60);
        chk("mid_hold", {30'd0, o8_mode}, 32'd0);
        px(0, 0, 1, 1, 40, 50, 60);
        chk("mid_byp", {8'd0, o8_data}, 32'h0A141E);
        px(0, 1, 1, 1, 255, 0, 0);
        chk("mid_new", {30'd0, o8_mode}, 32'd1);
        px(0, 0, 0, 1, 0, 0, 0);
        px(0, 0, 0, 1, 0, 0, 0);
        chk("mid_ycc", {8'd0, o8_data}, {8'd0, C_RED8});

        // de gating with nonzero data
        px(1, 0, 0, 1, 8'h12, 8'h34, 8'h56);
        px(0, 0, 0, 1, 8'h12, 8'h34, 8'h56);
        px(0, 0, 0, 1, 8'h12, 8'h34, 8'h56);
        chk("gate", {8'd0, o8_data}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) vs = ~vs;
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            px(1'($urandom_range(0, 1)), vs, 1'($urandom_range(0, 3) != 0), int'(mode),
               $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Mid-operation reset with a non-reset mode active
        px(0, 0, 1, 2, 1, 2, 3);
        px(1, 1, 1, 2, 200, 100, 50);
        chk("pre_rst_mode", {30'd0, o8_mode}, 32'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        vs = 0;
        #1 rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) vs = ~vs;
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            px(1'($urandom_range(0, 1)), vs, 1'($urandom_range(0, 3) != 0), int'(mode),
               $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
